// File: rtl/dac_spi_ctrl.sv
// ---------------------------------------------------------------------------
// dac_spi_ctrl
//
// Serial write controller for a 16-bit SPI-style DAC (DAC8551 / AD5662 class).
// A rising edge on ctrl, seen while idle, latches dato and shifts it out
// MSB-first. Each frame drives sync low and toggles sclk, which idles high.
// The DAC captures sdi on each falling sclk edge. After the frame, sync stays
// high for a guard gap before the next request is accepted.
//
// Parameters:
//   SCLK_HALF  clk_in cycles per sclk half-period (>= 1)
//   SYNC_GAP   clk_in cycles sync stays high after a frame while busy (>= 1)
//
// Ports:
//   clk_in  in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   ctrl    in   start request, rising-edge detected
//   dato    in   16-bit DAC code, sampled on the accepted start cycle
//   sync    out  frame select, active low
//   sdi     out  serial data, MSB first
//   sclk    out  serial clock, idles high
//   busy    out  high during a frame and its post-frame gap
//
// Optional feature (macro DAC_24BIT_FRAME_EN):
//   When defined, each frame is 24 bits. Eight zero control bits (normal
//   power mode) come first, followed by dato[15:0].
// ---------------------------------------------------------------------------
module dac_spi_ctrl #(
    parameter int SCLK_HALF = 1,
    parameter int SYNC_GAP  = 2
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        ctrl,
    input  logic [15:0] dato,
    output logic        sync,
    output logic        sdi,
    output logic        sclk,
    output logic        busy
);

`ifdef DAC_24BIT_FRAME_EN
    localparam int FRAME_BITS = 24;
`else
    localparam int FRAME_BITS = 16;
`endif

    localparam int HCW = $clog2(SCLK_HALF + 1);
    localparam int GCW = $clog2(SYNC_GAP + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_ctrl_d;
    logic [FRAME_BITS-1:0]   r_shreg;
    logic [4:0]              r_bit_cnt;
    logic [HCW-1:0]          r_half_cnt;
    logic [GCW-1:0]          r_gap_cnt;
    logic                    r_sync;
    logic                    r_sclk;
    logic                    r_sdi;
    logic                    r_busy;

    logic                    w_start;
    logic                    w_half_done;
    logic                    w_last_bit;
    logic                    w_gap_done;
    logic                    w_load;
    logic                    w_fall;
    logic                    w_rise;
    logic                    w_end;
    logic                    w_gap_exit;
    logic [FRAME_BITS-1:0]   w_load_word;
    logic                    w_first_bit;

    // The first bit goes straight to sdi when sync falls. The shift register
    // holds the remaining bits, left-aligned.
`ifdef DAC_24BIT_FRAME_EN
    assign w_first_bit = 1'b0;
    assign w_load_word = {7'b0, dato, 1'b0};
`else
    assign w_first_bit = dato[15];
    assign w_load_word = {dato[14:0], 1'b0};
`endif

    assign w_start     = ctrl & ~r_ctrl_d;
    assign w_half_done = (r_half_cnt == HCW'(SCLK_HALF - 1));
    assign w_last_bit  = (r_bit_cnt == 5'd0);
    assign w_gap_done  = (r_gap_cnt == GCW'(SYNC_GAP - 1));

    // State register
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = SHIFT;
            SHIFT:   if (w_half_done && !r_sclk && w_last_bit) w_state_nxt = GAP;
            GAP:     if (w_gap_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode. Each half-period boundary in SHIFT is one of three events:
    // a falling edge, a rising edge that presents the next bit, or the final
    // rising edge that closes the frame.
    always_comb begin
        w_load     = 1'b0;
        w_fall     = 1'b0;
        w_rise     = 1'b0;
        w_end      = 1'b0;
        w_gap_exit = 1'b0;
        case (r_state)
            IDLE:  w_load = w_start;
            SHIFT: begin
                if (w_half_done) begin
                    if (r_sclk)          w_fall = 1'b1;
                    else if (w_last_bit) w_end  = 1'b1;
                    else                 w_rise = 1'b1;
                end
            end
            GAP:     w_gap_exit = w_gap_done;
            default: ;
        endcase
    end

    // Datapath and registered pin drivers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl_d   <= 1'b0;
            r_shreg    <= '0;
            r_bit_cnt  <= 5'd0;
            r_half_cnt <= '0;
            r_gap_cnt  <= '0;
            r_sync     <= 1'b1;
            r_sclk     <= 1'b1;
            r_sdi      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_ctrl_d <= ctrl;
            if (w_load) begin
                r_shreg    <= w_load_word;
                r_sdi      <= w_first_bit;
                r_sync     <= 1'b0;
                r_sclk     <= 1'b1;
                r_busy     <= 1'b1;
                r_bit_cnt  <= 5'(FRAME_BITS - 1);
                r_half_cnt <= '0;
            end else if (r_state == SHIFT) begin
                r_half_cnt <= w_half_done ? '0 : r_half_cnt + HCW'(1);
                if (w_fall) begin
                    r_sclk <= 1'b0;
                end
                if (w_rise) begin
                    r_sclk    <= 1'b1;
                    r_sdi     <= r_shreg[FRAME_BITS-1];
                    r_shreg   <= r_shreg << 1;
                    r_bit_cnt <= r_bit_cnt - 5'd1;
                end
                if (w_end) begin
                    r_sclk    <= 1'b1;
                    r_sync    <= 1'b1;
                    r_sdi     <= 1'b0;
                    r_gap_cnt <= '0;
                end
            end else if (r_state == GAP) begin
                r_gap_cnt <= r_gap_cnt + GCW'(1);
                if (w_gap_exit) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign sync = r_sync;
    assign sclk = r_sclk;
    assign sdi  = r_sdi;
    assign busy = r_busy;

endmodule

// File: tb/tb_dac_spi_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dac_spi_ctrl
//
// Drives two dac_spi_ctrl instances, one with SCLK_HALF=1 and one with
// SCLK_HALF=3. A pin-level monitor decodes each frame as the DAC would see it:
// it captures sdi on falling sclk edges while sync is low and measures how long
// sync stays low. Expected words and acceptance of requests come from
// plain cycle arithmetic on when each ctrl edge happens.
// Honours DAC_24BIT_FRAME_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_dac_spi_ctrl;

    localparam int H0 = 1;
    localparam int H1 = 3;
    localparam int G  = 2;
`ifdef DAC_24BIT_FRAME_EN
    localparam int NB = 24;
`else
    localparam int NB = 16;
`endif

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b1;
    logic        ctrl0  = 1'b0;
    logic        ctrl1  = 1'b0;
    logic [15:0] dato0  = 16'h0;
    logic [15:0] dato1  = 16'h0;
    logic        sync0, sdi0, sclk0, busy0;
    logic        sync1, sdi1, sclk1, busy1;

    dac_spi_ctrl #(.SCLK_HALF(H0), .SYNC_GAP(G)) dut_fast (
        .clk_in(clk_in), .rst_n(rst_n), .ctrl(ctrl0), .dato(dato0),
        .sync(sync0), .sdi(sdi0), .sclk(sclk0), .busy(busy0)
    );

    dac_spi_ctrl #(.SCLK_HALF(H1), .SYNC_GAP(G)) dut_slow (
        .clk_in(clk_in), .rst_n(rst_n), .ctrl(ctrl1), .dato(dato1),
        .sync(sync1), .sdi(sdi1), .sclk(sclk1), .busy(busy1)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_err = 0;
    int pc    = 0;

    always @(posedge clk_in) pc++;

    typedef struct {
        int          id;
        logic [23:0] word;
        int          low;
        int          falls;
    } frame_t;

    frame_t fq[$];

    int          m_low[2]      = '{0, 0};
    int          m_falls[2]    = '{0, 0};
    int          m_since[2]    = '{0, 0};
    int          m_lastfall[2] = '{-1, -1};
    int          m_terr[2]     = '{0, 0};
    logic [23:0] m_word[2]     = '{24'h0, 24'h0};
    logic        m_psync[2]    = '{1'b1, 1'b1};
    logic        m_psclk[2]    = '{1'b1, 1'b1};
    logic        m_psdi[2]     = '{1'b0, 1'b0};
    int          ncyc          = 0;

    // Pin-level frame decoder. It also counts timing errors: sdi must stay
    // stable for at least one half-period on each side of a falling edge, and
    // falling edges must be exactly one sclk period apart.
    always @(negedge clk_in) begin
        logic   s, c, d;
        int     h;
        frame_t f;
        ncyc++;
        for (int k = 0; k < 2; k++) begin
            s = (k == 0) ? sync0 : sync1;
            c = (k == 0) ? sclk0 : sclk1;
            d = (k == 0) ? sdi0  : sdi1;
            h = (k == 0) ? H0 : H1;
            if (d !== m_psdi[k]) begin
                if (m_lastfall[k] >= 0 && (ncyc - m_lastfall[k]) < h) m_terr[k]++;
                m_since[k] = 0;
            end else begin
                m_since[k]++;
            end
            if (s === 1'b0) begin
                if (m_psync[k] === 1'b1) begin
                    m_low[k]      = 0;
                    m_falls[k]    = 0;
                    m_word[k]     = 24'h0;
                    m_since[k]    = 0;
                    m_lastfall[k] = -1;
                end
                m_low[k]++;
                if (m_psclk[k] === 1'b1 && c === 1'b0) begin
                    m_falls[k]++;
                    m_word[k] = {m_word[k][22:0], d};
                    if (m_since[k] < h) m_terr[k]++;
                    if (m_lastfall[k] >= 0 && (ncyc - m_lastfall[k]) != 2 * h) m_terr[k]++;
                    m_lastfall[k] = ncyc;
                end
            end else if (m_psync[k] === 1'b0) begin
                f.id    = k;
                f.word  = m_word[k];
                f.low   = m_low[k];
                f.falls = m_falls[k];
                fq.push_back(f);
                m_lastfall[k] = -1;
            end
            m_psync[k] = s;
            m_psclk[k] = c;
            m_psdi[k]  = d;
        end
    end

    function automatic logic get_sync(int k); return (k == 0) ? sync0 : sync1; endfunction
    function automatic logic get_sclk(int k); return (k == 0) ? sclk0 : sclk1; endfunction
    function automatic logic get_sdi(int k);  return (k == 0) ? sdi0  : sdi1;  endfunction
    function automatic logic get_busy(int k); return (k == 0) ? busy0 : busy1; endfunction

    task automatic set_ctrl(int k, logic v);
        if (k == 0) ctrl0 = v; else ctrl1 = v;
    endtask

    task automatic set_dato(int k, logic [15:0] v);
        if (k == 0) dato0 = v; else dato1 = v;
    endtask

    // One-cycle ctrl pulse; returns at the negedge after the sampling posedge.
    task automatic pulse(int k);
        @(negedge clk_in);
        set_ctrl(k, 1'b1);
        @(negedge clk_in);
        set_ctrl(k, 1'b0);
    endtask

    task automatic wait_idle(int k, int budget, output bit tout);
        int n;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (get_busy(k) === 1'b1 && n < budget);
        tout = (get_busy(k) !== 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (5) @(negedge clk_in);
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (get_sync(k) !== 1'b1) begin n_err++; $display("[TB] FAIL reset_sync[%0d]: got %b want 1", k, get_sync(k)); end
            n_cmp++; if (get_sclk(k) !== 1'b1) begin n_err++; $display("[TB] FAIL reset_sclk[%0d]: got %b want 1", k, get_sclk(k)); end
            n_cmp++; if (get_sdi(k)  !== 1'b0) begin n_err++; $display("[TB] FAIL reset_sdi[%0d]: got %b want 0", k, get_sdi(k)); end
            n_cmp++; if (get_busy(k) !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy[%0d]: got %b want 0", k, get_busy(k)); end
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk_in);
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (get_sync(k) !== 1'b1) begin n_err++; $display("[TB] FAIL post_reset_sync[%0d]: got %b want 1", k, get_sync(k)); end
            n_cmp++; if (get_sclk(k) !== 1'b1) begin n_err++; $display("[TB] FAIL post_reset_sclk[%0d]: got %b want 1", k, get_sclk(k)); end
            n_cmp++; if (get_sdi(k)  !== 1'b0) begin n_err++; $display("[TB] FAIL post_reset_sdi[%0d]: got %b want 0", k, get_sdi(k)); end
            n_cmp++; if (get_busy(k) !== 1'b0) begin n_err++; $display("[TB] FAIL post_reset_busy[%0d]: got %b want 0", k, get_busy(k)); end
        end
    endtask

    task automatic test_single_write;
        int   n;
        logic first;
        fq.delete();
        m_terr[0] = 0;
        first = (NB == 24) ? 1'b0 : 1'b1;
        dato0 = 16'hCAAA;
        pulse(0);
        n_cmp++; if (sync0 !== 1'b0) begin n_err++; $display("[TB] FAIL single_sync_fall: got %b want 0", sync0); end
        n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("[TB] FAIL single_busy_rise: got %b want 1", busy0); end
        n_cmp++; if (sdi0 !== first) begin n_err++; $display("[TB] FAIL single_first_bit: got %b want %b", sdi0, first); end
        n = 0;
        while (sync0 !== 1'b1 && n < 1000) begin @(negedge clk_in); n++; end
        n_cmp++; if (sync0 !== 1'b1) begin n_err++; $display("[TB] FAIL single_sync_timeout: got %b want 1", sync0); end
        n = 0;
        while (busy0 === 1'b1 && n < 100) begin @(negedge clk_in); n++; end
        n_cmp++; if (n != G) begin n_err++; $display("[TB] FAIL single_gap_len: got %0d want %0d", n, G); end
        n_cmp++; if (sdi0 !== 1'b0) begin n_err++; $display("[TB] FAIL single_sdi_after: got %b want 0", sdi0); end
        n_cmp++; if (sclk0 !== 1'b1) begin n_err++; $display("[TB] FAIL single_sclk_after: got %b want 1", sclk0); end
        n_cmp++; if (fq.size() != 1) begin n_err++; $display("[TB] FAIL single_frames: got %0d want 1", fq.size()); end
        if (fq.size() >= 1) begin
            n_cmp++; if (fq[0].word !== 24'h00CAAA) begin n_err++; $display("[TB] FAIL single_word: got %h want 00caaa", fq[0].word); end
            n_cmp++; if (fq[0].low != 2 * NB * H0) begin n_err++; $display("[TB] FAIL single_low: got %0d want %0d", fq[0].low, 2 * NB * H0); end
            n_cmp++; if (fq[0].falls != NB) begin n_err++; $display("[TB] FAIL single_falls: got %0d want %0d", fq[0].falls, NB); end
        end
        n_cmp++; if (m_terr[0] != 0) begin n_err++; $display("[TB] FAIL single_timing: got %0d errors want 0", m_terr[0]); end
    endtask

    task automatic test_ctrl_held;
        bit tout;
        fq.delete();
        dato0 = 16'h0001;
        @(negedge clk_in);
        ctrl0 = 1'b1;
        repeat (100) @(negedge clk_in);
        ctrl0 = 1'b0;
        wait_idle(0, 1000, tout);
        repeat (2 * NB * H0 + 10) @(negedge clk_in);
        n_cmp++; if (tout) begin n_err++; $display("[TB] FAIL held_timeout: got busy %b want 0", busy0); end
        n_cmp++; if (fq.size() != 1) begin n_err++; $display("[TB] FAIL held_frames: got %0d want 1", fq.size()); end
        if (fq.size() >= 1) begin
            n_cmp++; if (fq[0].word !== 24'h000001) begin n_err++; $display("[TB] FAIL held_word: got %h want 000001", fq[0].word); end
        end
    endtask

    task automatic test_drop_midframe;
        bit tout;
        fq.delete();
        dato0 = 16'hFFFF;
        pulse(0);
        repeat (10) @(negedge clk_in);
        dato0 = 16'h1234;
        pulse(0);
        wait_idle(0, 1000, tout);
        repeat (2 * NB * H0 + 10) @(negedge clk_in);
        n_cmp++; if (tout) begin n_err++; $display("[TB] FAIL drop_timeout: got busy %b want 0", busy0); end
        n_cmp++; if (fq.size() != 1) begin n_err++; $display("[TB] FAIL drop_frames: got %0d want 1", fq.size()); end
        if (fq.size() >= 1) begin
            n_cmp++; if (fq[0].word !== 24'h00FFFF) begin n_err++; $display("[TB] FAIL drop_word: got %h want 00ffff", fq[0].word); end
        end
        n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("[TB] FAIL drop_busy_end: got %b want 0", busy0); end
    endtask

    task automatic test_reset_midframe;
        int n;
        bit tout;
        dato0 = 16'h4321;
        pulse(0);
        n = 0;
        #1;
        while (m_falls[0] != 5 && n < 1000) begin @(negedge clk_in); #1; n++; end
        n_cmp++; if (m_falls[0] != 5) begin n_err++; $display("[TB] FAIL rstmid_wait: got %0d falls want 5", m_falls[0]); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (sync0 !== 1'b1) begin n_err++; $display("[TB] FAIL rstmid_sync: got %b want 1", sync0); end
        n_cmp++; if (sclk0 !== 1'b1) begin n_err++; $display("[TB] FAIL rstmid_sclk: got %b want 1", sclk0); end
        n_cmp++; if (sdi0  !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_sdi: got %b want 0", sdi0); end
        n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_busy: got %b want 0", busy0); end
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_in);
        fq.delete();
        m_terr[0] = 0;
        dato0 = 16'h8001;
        pulse(0);
        wait_idle(0, 1000, tout);
        n_cmp++; if (tout) begin n_err++; $display("[TB] FAIL rstmid_timeout: got busy %b want 0", busy0); end
        n_cmp++; if (fq.size() != 1) begin n_err++; $display("[TB] FAIL rstmid_frames: got %0d want 1", fq.size()); end
        if (fq.size() >= 1) begin
            n_cmp++; if (fq[0].word !== 24'h008001) begin n_err++; $display("[TB] FAIL rstmid_word: got %h want 008001", fq[0].word); end
            n_cmp++; if (fq[0].falls != NB) begin n_err++; $display("[TB] FAIL rstmid_falls: got %0d want %0d", fq[0].falls, NB); end
            n_cmp++; if (fq[0].low != 2 * NB * H0) begin n_err++; $display("[TB] FAIL rstmid_low: got %0d want %0d", fq[0].low, 2 * NB * H0); end
        end
    endtask

    task automatic test_slow_sclk;
        bit tout;
        fq.delete();
        m_terr[1] = 0;
        dato1 = 16'h5555;
        pulse(1);
        wait_idle(1, 2000, tout);
        n_cmp++; if (tout) begin n_err++; $display("[TB] FAIL slow_timeout: got busy %b want 0", busy1); end
        n_cmp++; if (fq.size() != 1) begin n_err++; $display("[TB] FAIL slow_frames: got %0d want 1", fq.size()); end
        if (fq.size() >= 1) begin
            n_cmp++; if (fq[0].word !== 24'h005555) begin n_err++; $display("[TB] FAIL slow_word: got %h want 005555", fq[0].word); end
            n_cmp++; if (fq[0].low != 2 * NB * H1) begin n_err++; $display("[TB] FAIL slow_low: got %0d want %0d", fq[0].low, 2 * NB * H1); end
            n_cmp++; if (fq[0].falls != NB) begin n_err++; $display("[TB] FAIL slow_falls: got %0d want %0d", fq[0].falls, NB); end
        end
        n_cmp++; if (m_terr[1] != 0) begin n_err++; $display("[TB] FAIL slow_timing: got %0d errors want 0", m_terr[1]); end
        n_cmp++; if (sclk1 !== 1'b1 || sync1 !== 1'b1) begin n_err++; $display("[TB] FAIL slow_idle_pins: got sclk %b sync %b want 1 1", sclk1, sync1); end
    endtask

    // Random request trains. A rising ctrl edge sampled at posedge e is taken
    // only if the previous accepted frame (sync low 2*NB*h cycles, then G gap
    // cycles) has fully finished by then.
    task automatic test_random(int k);
        int          h, flen, free, e, gap, w, n;
        logic [15:0] d;
        logic [15:0] exp_q[$];
        h    = (k == 0) ? H0 : H1;
        flen = 2 * NB * h;
        fq.delete();
        m_terr[k] = 0;
        free = pc + 1;
        for (int it = 0; it < 10; it++) begin
            gap = $urandom_range(1, flen + G + 4);
            repeat (gap) @(negedge clk_in);
            d = 16'($urandom);
            set_dato(k, d);
            e = pc + 1;
            set_ctrl(k, 1'b1);
            if (e >= free) begin
                exp_q.push_back(d);
                free = e + flen + G + 1;
            end
            w = $urandom_range(1, 3);
            repeat (w) begin
                @(negedge clk_in);
                set_dato(k, 16'($urandom));
            end
            set_ctrl(k, 1'b0);
        end
        n = 0;
        while ((pc < free + 2 || get_busy(k) === 1'b1) && n < 5000) begin @(negedge clk_in); n++; end
        n_cmp++; if (get_busy(k) !== 1'b0) begin n_err++; $display("[TB] FAIL rand%0d_timeout: got busy %b want 0", k, get_busy(k)); end
        n_cmp++; if (fq.size() != exp_q.size()) begin n_err++; $display("[TB] FAIL rand%0d_frames: got %0d want %0d", k, fq.size(), exp_q.size()); end
        for (int i = 0; i < fq.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (fq[i].word !== {8'h00, exp_q[i]}) begin n_err++; $display("[TB] FAIL rand%0d_word[%0d]: got %h want %h", k, i, fq[i].word, {8'h00, exp_q[i]}); end
            n_cmp++; if (fq[i].low != flen || fq[i].falls != NB) begin n_err++; $display("[TB] FAIL rand%0d_shape[%0d]: got low %0d falls %0d want %0d %0d", k, i, fq[i].low, fq[i].falls, flen, NB); end
        end
        n_cmp++; if (m_terr[k] != 0) begin n_err++; $display("[TB] FAIL rand%0d_timing: got %0d errors want 0", k, m_terr[k]); end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] dac_spi_ctrl bench, frame bits %0d", NB);
        test_reset();
        test_single_write();
        test_ctrl_held();
        test_drop_midframe();
        test_reset_midframe();
        test_slow_sclk();
        test_random(0);
        test_random(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
